// File: rtl/vga_timing_controller.sv
// VGA raster timing generator: sub-pixel, column and line counters with registered
// sync/blank/coordinate decode, plus run/stop control that only acts on frame boundaries.
module vga_timing_controller #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_tick,
    output logic       line_start,
    output logic       frame_start,
    output logic       busy
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int SUB_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SUB_W-1:0] sub;
    logic [SUB_W-1:0] sub_next;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             at_sub_last;
    logic             at_line_end;
    logic             at_frame_end;

    // The decode is taken from the next counter values so every registered output
    // lines up with the counters it is presented alongside.
    always_comb begin
        at_sub_last  = (sub == SUB_LAST);
        at_line_end  = at_sub_last && (pixel_x == H_LAST);
        at_frame_end = at_line_end && (pixel_y == V_LAST);
        state_next   = state;
        sub_next     = '0;
        x_next       = '0;
        y_next       = '0;
        case (state)
            IDLE: begin
                state_next = enable ? RUN : IDLE;
            end
            RUN, DRAIN: begin
                sub_next = at_sub_last ? '0 : sub + 1'b1;
                x_next   = pixel_x;
                y_next   = pixel_y;
                if (at_sub_last) begin
                    x_next = (pixel_x == H_LAST) ? 10'd0 : pixel_x + 10'd1;
                end
                if (at_line_end) begin
                    y_next = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
                end
                if (enable) begin
                    state_next = RUN;
                end else if (at_frame_end) begin
                    state_next = IDLE;
                end else begin
                    state_next = DRAIN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (state_next == IDLE) begin
            sub_next = '0;
            x_next   = '0;
            y_next   = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= IDLE;
            sub         <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pixel_tick  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state   <= state_next;
            sub     <= sub_next;
            pixel_x <= x_next;
            pixel_y <= y_next;
            if (state_next == IDLE) begin
                hsync       <= 1'b1;
                vsync       <= 1'b1;
                video_on    <= 1'b0;
                pixel_tick  <= 1'b0;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
                busy        <= 1'b0;
            end else begin
                hsync       <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
                vsync       <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
                video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
                pixel_tick  <= (sub_next == SUB_LAST);
                line_start  <= (sub_next == '0) && (x_next == 10'd0);
                frame_start <= (sub_next == '0) && (x_next == 10'd0) && (y_next == 10'd0);
                busy        <= 1'b1;
            end
        end
    end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Sequences the VGA raster for the display path. Runs the 1600-clock line counter (800 pixels × 2 clocks per pixel) and a 525-line frame counter.
- Decodes hsync, vsync, blanking and pixel coordinates from those counters.
- Adds run/stop control so the raster starts and stops only on frame boundaries. Downstream pixel generators never see a partial frame.

Parameters:
- CLK_DIV, 2, Clk cycles per pixel
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels); H_TOTAL = 800
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = 525

Ports:
- Clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  request raster to run; level-sensitive
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high inside visible area
- pixel_x  out  10  current pixel column, 0..799
- pixel_y  out  10  current line, 0..524
- pixel_tick  out  1  high on the last Clk of each pixel
- line_start  out  1  one-Clk pulse on first Clk of each line
- frame_start  out  1  one-Clk pulse on first Clk of each frame
- busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset: state IDLE; sub-pixel counter, pixel_x, pixel_y = 0; hsync = vsync = 1; video_on = pixel_tick = line_start = frame_start = busy = 0. Reset overrides every other input, including mid-frame.
- Counters:
  - sub counts 0..CLK_DIV-1 and wraps.
  - pixel_x increments when sub wraps, and wraps 799→0.
  - pixel_y increments when pixel_x wraps, and wraps 524→0.
  - Line period is 1600 Clk; frame period is 840000 Clk.
  - All widths are unsigned; wrap is compare-and-clear, never overflow.
- Decode: all decoded outputs are registered and consistent with the pixel_x/pixel_y/sub values presented in the same cycle.
  - hsync = 0 iff 656 <= pixel_x <= 751.
  - vsync = 0 iff 490 <= pixel_y <= 491.
  - video_on = 1 iff pixel_x < 640 and pixel_y < 480.
  - pixel_tick = 1 iff sub == CLK_DIV-1.
  - line_start = 1 iff sub == 0 and pixel_x == 0.
  - frame_start = line_start and pixel_y == 0.
- FSM (Moore) is part of the same registered decode, with states IDLE, RUN, DRAIN:
  - IDLE:
    - Counters held at 0; outputs at reset values.
    - enable = 1 → RUN. The first RUN cycle presents sub=0, x=0, y=0 with frame_start = line_start = 1 and busy = 1.
  - RUN:
    - Counters free-run.
    - enable = 0 → DRAIN. Counters are not disturbed.
  - DRAIN:
    - Counters continue.
    - enable = 1 → RUN, no counter disturbance, no extra frame_start.
    - On the final Clk of the frame (sub=CLK_DIV-1, x=799, y=524) with enable = 0 → IDLE. The next cycle shows reset-value outputs and busy = 0.
  - Simultaneous case: in the final Clk of a frame while in DRAIN, enable = 1 wins, and the state goes to RUN.
  - enable toggling within a frame never shortens or restarts the frame.
- Latency:
  - enable rising in IDLE → frame_start one Clk later.
  - enable falling → raster stops at the next frame boundary.

Test Plan:
- Reset sequence: assert reset 3 cycles with enable = 1 → hsync = vsync = 1, video_on = 0, pixel_x = pixel_y = 0, busy = 0. Release → frame_start = 1 on the next Clk.
- Horizontal timing:
  - hsync low for exactly 192 Clk, starting 1312 Clk after line_start.
  - video_on high for 1280 Clk per visible line.
  - line_start period is 1600 Clk.
  - pixel_tick is high every 2nd Clk.
- Vertical timing:
  - vsync low for exactly 3200 Clk, starting at the line_start of line 490.
  - frame_start period is 840000 Clk.
  - video_on is never high for pixel_y >= 480.
- Drain: drop enable at pixel_y = 100 → busy stays 1 and counters continue until x=799/y=524 completes, then busy = 0 with outputs at idle values. No further frame_start while enable = 0.
- Re-enable during drain: drop enable at y = 100, raise it at y = 300 → no discontinuity in pixel_x/pixel_y, busy never falls, next frame_start is exactly 840000 Clk after the previous one.
- Reset mid-frame: assert reset at x = 400, y = 200 → next cycle all outputs at reset values. With enable held high, frame_start occurs one Clk after reset release.
